// File: rtl/ecc_pkg.sv
// Shared definitions for the SECDED channel core: FSM state codes, mode and
// width selector codes, codeword geometry lookups and bit-placement helpers.
package ecc_pkg;

    // FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ENC   = 3'd1;
    localparam state_t ST_NOISE = 3'd2;
    localparam state_t ST_DEC   = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    // CTRL[1:0] operation modes (2'b11 is invalid)
    localparam logic [1:0] ENCODE = 2'b00;
    localparam logic [1:0] DECODE = 2'b01;
    localparam logic [1:0] FULL   = 2'b10;

    // CODEWORD_WIDTH[1:0] codes (2'b11 is invalid)
    localparam logic [1:0] WIDTH_8  = 2'b00;
    localparam logic [1:0] WIDTH_16 = 2'b01;
    localparam logic [1:0] WIDTH_32 = 2'b10;

    // Codeword (N) and data (K) lengths per width code
    localparam int unsigned N_8  = 8;
    localparam int unsigned K_8  = 4;
    localparam int unsigned N_16 = 16;
    localparam int unsigned K_16 = 11;
    localparam int unsigned N_32 = 32;
    localparam int unsigned K_32 = 26;

    function automatic int unsigned cw_len(input logic [1:0] w);
        case (w)
            WIDTH_8:  return N_8;
            WIDTH_16: return N_16;
            WIDTH_32: return N_32;
            default:  return 0;
        endcase
    endfunction

    function automatic logic [31:0] cw_mask(input logic [1:0] w);
        case (w)
            WIDTH_8:  return 32'h0000_00FF;
            WIDTH_16: return 32'h0000_FFFF;
            WIDTH_32: return 32'hFFFF_FFFF;
            default:  return '0;
        endcase
    endfunction

    function automatic logic is_pow2(input int unsigned j);
        return ((j & (j - 1)) == 0);
    endfunction

    // Places data bits at the non-power-of-two positions below N, LSB first.
    // Parity positions and bit 0 are left at zero.
    function automatic logic [31:0] scatter_data(input logic [31:0] d, input logic [1:0] w);
        logic [31:0] cw;
        int unsigned k;
        int unsigned n;
        cw = '0;
        k  = 0;
        n  = cw_len(w);
        for (int unsigned j = 1; j < 32; j++) begin
            if (j < n && !is_pow2(j)) begin
                cw[j[4:0]] = d[k[4:0]];
                k++;
            end
        end
        return cw;
    endfunction

    // Inverse of scatter_data: collects the data positions back into K bits.
    function automatic logic [31:0] gather_data(input logic [31:0] cw, input logic [1:0] w);
        logic [31:0] d;
        int unsigned k;
        int unsigned n;
        d = '0;
        k = 0;
        n = cw_len(w);
        for (int unsigned j = 1; j < 32; j++) begin
            if (j < n && !is_pow2(j)) begin
                d[k[4:0]] = cw[j[4:0]];
                k++;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/ecc_hamming_calc.sv
// Combinational Hamming kernel: masks a 32-bit vector to N bits and returns
// the XOR of set-bit indices (parity bits when fed a data-only vector,
// syndrome when fed a codeword) plus the overall parity of the N bits.
module ecc_hamming_calc
    import ecc_pkg::*;
(
    input  logic [31:0] vec_i,
    input  logic [1:0]  width_i,
    output logic [4:0]  syndrome_o,
    output logic        parity_o
);

    logic [31:0] masked;
    logic [4:0]  syn;

    // Index-XOR syndrome and overall parity of the masked vector
    always_comb begin
        masked = vec_i & cw_mask(width_i);
        syn    = '0;
        for (int unsigned j = 1; j < 32; j++) begin
            if (masked[j[4:0]]) begin
                syn = syn ^ j[4:0];
            end
        end
        syndrome_o = syn;
        parity_o   = ^masked;
    end

endmodule

// File: rtl/ecc_channel_core.sv
// SECDED encode / decode / encode-noise-decode channel core. Operands are
// captured on start, processed through a one-cycle-per-state FSM, and the
// registered result is presented with a one-cycle operation_done pulse.
module ecc_channel_core
    import ecc_pkg::*;
#(
    parameter int AMBA_WORD = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AMBA_WORD-1:0] CTRL,
    input  logic [AMBA_WORD-1:0] DATA_IN,
    input  logic [AMBA_WORD-1:0] CODEWORD_WIDTH,
    input  logic [AMBA_WORD-1:0] NOISE,
    output logic [AMBA_WORD-1:0] data_out,
    output logic                 operation_done,
    output logic [1:0]           num_of_errors
);

    state_t      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [1:0]  width_q, width_d;
    logic [31:0] data_q, data_d;
    logic [31:0] noise_q, noise_d;
    logic [31:0] cw_q, cw_d;
    logic [31:0] data_out_q, data_out_d;
    logic [1:0]  nerr_q, nerr_d;
    logic        done_q, done_d;

    logic [31:0] calc_vec;
    logic [4:0]  syn;
    logic        par;
    logic [31:0] enc_cw;
    logic [31:0] fixed_cw;

    logic unused_bits;
    assign unused_bits = ^{CTRL[AMBA_WORD-1:2], CODEWORD_WIDTH[AMBA_WORD-1:2]};

    // Kernel operand: scattered data in ENC, received codeword in DEC
    always_comb begin
        calc_vec = '0;
        if (state_q == ST_ENC) begin
            calc_vec = scatter_data(data_q, width_q);
        end else if (state_q == ST_DEC) begin
            calc_vec = ((mode_q == DECODE) ? data_q : cw_q) & cw_mask(width_q);
        end
    end

    ecc_hamming_calc u_calc (
        .vec_i      (calc_vec),
        .width_i    (width_q),
        .syndrome_o (syn),
        .parity_o   (par)
    );

    // Next-state, operand capture and result computation
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        width_d    = width_q;
        data_d     = data_q;
        noise_d    = noise_q;
        cw_d       = cw_q;
        data_out_d = data_out_q;
        nerr_d     = nerr_q;

        // Syndrome of the data-only vector is exactly the parity bits; bit 0
        // then needs the data parity plus the parity of those parity bits.
        enc_cw    = calc_vec;
        enc_cw[1]  = syn[0];
        enc_cw[2]  = syn[1];
        enc_cw[4]  = syn[2];
        enc_cw[8]  = syn[3];
        enc_cw[16] = syn[4];
        enc_cw[0]  = par ^ (^syn);

        fixed_cw = calc_vec;
        if (par) begin
            fixed_cw[syn] = ~calc_vec[syn];
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = CTRL[1:0];
                    width_d = CODEWORD_WIDTH[1:0];
                    data_d  = DATA_IN[31:0];
                    noise_d = NOISE[31:0];
                    if (CTRL[1:0] == 2'b11 || CODEWORD_WIDTH[1:0] == 2'b11) begin
                        state_d    = ST_DONE;
                        data_out_d = '0;
                        nerr_d     = 2'd0;
                    end else if (CTRL[1:0] == DECODE) begin
                        state_d = ST_DEC;
                    end else begin
                        state_d = ST_ENC;
                    end
                end
            end
            ST_ENC: begin
                cw_d = enc_cw;
                if (mode_q == FULL) begin
                    state_d = ST_NOISE;
                end else begin
                    state_d    = ST_DONE;
                    data_out_d = enc_cw;
                    nerr_d     = 2'd0;
                end
            end
            ST_NOISE: begin
                cw_d    = cw_q ^ (noise_q & cw_mask(width_q));
                state_d = ST_DEC;
            end
            ST_DEC: begin
                state_d    = ST_DONE;
                data_out_d = gather_data(fixed_cw, width_q);
                if (par) begin
                    nerr_d = 2'd1;
                end else if (syn != '0) begin
                    nerr_d = 2'd2;
                end else begin
                    nerr_d = 2'd0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers, asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= '0;
            width_q    <= '0;
            data_q     <= '0;
            noise_q    <= '0;
            cw_q       <= '0;
            data_out_q <= '0;
            nerr_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            width_q    <= width_d;
            data_q     <= data_d;
            noise_q    <= noise_d;
            cw_q       <= cw_d;
            data_out_q <= data_out_d;
            nerr_q     <= nerr_d;
            done_q     <= done_d;
        end
    end

    assign data_out       = AMBA_WORD'(data_out_q);
    assign num_of_errors  = nerr_q;
    assign operation_done = done_q;

endmodule

// File: tb/tb_ecc_channel_core.sv
// Directed self-checking bench for ecc_channel_core with hand-computed vectors.
module tb_ecc_channel_core;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] CTRL;
    logic [31:0] DATA_IN;
    logic [31:0] CODEWORD_WIDTH;
    logic [31:0] NOISE;
    logic [31:0] data_out;
    logic        operation_done;
    logic [1:0]  num_of_errors;

    int checks   = 0;
    int failures = 0;

    ecc_channel_core #(.AMBA_WORD(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .CTRL           (CTRL),
        .DATA_IN        (DATA_IN),
        .CODEWORD_WIDTH (CODEWORD_WIDTH),
        .NOISE          (NOISE),
        .data_out       (data_out),
        .operation_done (operation_done),
        .num_of_errors  (num_of_errors)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one operation, then checks latency, results, pulse width and hold.
    task automatic run_op(input string tag, input logic [1:0] c, input logic [1:0] w,
                          input logic [31:0] d, input logic [31:0] nz,
                          input int exp_lat, input logic [31:0] exp_d, input logic [1:0] exp_e);
        int lat;
        lat = -1;
        @(posedge clk); #1;
        CTRL = {30'd0, c}; CODEWORD_WIDTH = {30'd0, w}; DATA_IN = d; NOISE = nz;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        DATA_IN = ~d; NOISE = ~nz;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (operation_done === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_data"}, data_out, exp_d);
        chk({tag, "_err"}, {30'd0, num_of_errors}, {30'd0, exp_e});
        @(negedge clk);
        chk({tag, "_pulse"}, {31'd0, operation_done}, 32'd0);
        chk({tag, "_hold"}, data_out, exp_d);
    endtask

    initial begin
        int seen;
        rst = 1'b0; start = 1'b0;
        CTRL = '0; DATA_IN = '0; CODEWORD_WIDTH = '0; NOISE = '0;
        #12;
        chk("rst_data", data_out, 32'd0);
        chk("rst_err", {30'd0, num_of_errors}, 32'd0);
        chk("rst_done", {31'd0, operation_done}, 32'd0);
        @(negedge clk); rst = 1'b1;

        run_op("enc8",      2'd0, 2'd0, 32'h0000_000B, 32'h0, 2, 32'hAA, 2'd0);
        run_op("enc8_hi",   2'd0, 2'd0, 32'hFFFF_FFFB, 32'h0, 2, 32'hAA, 2'd0);
        run_op("full8_1e",  2'd2, 2'd0, 32'h0000_000B, 32'h8, 4, 32'hB, 2'd1);
        run_op("full8_2e",  2'd2, 2'd0, 32'h0000_000B, 32'h30, 4, 32'h9, 2'd2);
        run_op("dec8_b0",   2'd1, 2'd0, 32'h0000_00AB, 32'h0, 2, 32'hB, 2'd1);
        run_op("dec8_ok",   2'd1, 2'd0, 32'h0000_00AA, 32'h0, 2, 32'hB, 2'd0);
        run_op("dec8_hi",   2'd1, 2'd0, 32'hFFFF_FFAA, 32'h0, 2, 32'hB, 2'd0);
        run_op("enc16",     2'd0, 2'd1, 32'h0000_07FF, 32'h0, 2, 32'hFFFF, 2'd0);
        run_op("dec16",     2'd1, 2'd1, 32'h0000_FFFF, 32'h0, 2, 32'h7FF, 2'd0);
        run_op("full16_1e", 2'd2, 2'd1, 32'h0000_07FF, 32'h0010_0400, 4, 32'h7FF, 2'd1);
        run_op("enc32",     2'd0, 2'd2, 32'h0000_0001, 32'h0, 2, 32'hF, 2'd0);
        run_op("dec32",     2'd1, 2'd2, 32'h0000_000F, 32'h0, 2, 32'h1, 2'd0);
        run_op("full32_b31",2'd2, 2'd2, 32'h0000_0001, 32'h8000_0000, 4, 32'h1, 2'd1);
        run_op("inv_mode",  2'd3, 2'd0, 32'h0000_000B, 32'h0, 1, 32'h0, 2'd0);
        run_op("enc8_b",    2'd0, 2'd0, 32'h0000_000B, 32'h0, 2, 32'hAA, 2'd0);
        run_op("inv_width", 2'd0, 2'd3, 32'h0000_000B, 32'h0, 1, 32'h0, 2'd0);

        // Second start while in ENC must be ignored
        @(posedge clk); #1;
        CTRL = 32'd0; CODEWORD_WIDTH = 32'd0; DATA_IN = 32'hB; start = 1'b1;
        @(posedge clk); #1;
        CTRL = 32'd1; DATA_IN = 32'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_done", {31'd0, operation_done}, 32'd1);
        chk("busy_data", data_out, 32'hAA);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (operation_done === 1'b1) seen++;
        end
        chk("busy_single", seen, 0);

        // Reset while in NOISE aborts the operation
        @(posedge clk); #1;
        CTRL = 32'd2; CODEWORD_WIDTH = 32'd0; DATA_IN = 32'hB; NOISE = 32'h8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("abort_data", data_out, 32'd0);
        chk("abort_err", {30'd0, num_of_errors}, 32'd0);
        chk("abort_done", {31'd0, operation_done}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (operation_done === 1'b1) seen++;
        end
        chk("abort_nodone", seen, 0);
        run_op("after_rst", 2'd2, 2'd0, 32'h0000_000B, 32'h8, 4, 32'hB, 2'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ecc_channel_core.md
ECC_CHANNEL_CORE -- requirements
Module: ecc_channel_core

Interface
REQ-001 The block SHALL have parameter AMBA_WORD, default 32, meaning the register/data word width.
REQ-002 The block SHALL have port clk  input  1  system clock.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port start  input  1  one-cycle operation request from the APB register stage.
REQ-005 The block SHALL have port CTRL  input  AMBA_WORD  mode selector; only [1:0] is used.
REQ-006 The block SHALL have port DATA_IN  input  AMBA_WORD  data word to encode, or codeword to decode.
REQ-007 The block SHALL have port CODEWORD_WIDTH  input  AMBA_WORD  width selector; only [1:0] is used.
REQ-008 The block SHALL have port NOISE  input  AMBA_WORD  XOR error mask, used in full mode only.
REQ-009 The block SHALL have port data_out  output  AMBA_WORD  result word, zero-extended.
REQ-010 The block SHALL have port operation_done  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have port num_of_errors  output  2  number of detected errors: 0, 1 or 2.

Function
REQ-012 CTRL[1:0] SHALL select the mode: 00 encode, 01 decode, 10 full (encode, then XOR NOISE, then decode), 11 invalid.
REQ-013 CODEWORD_WIDTH[1:0] SHALL select the codeword length N and data length K: 00 gives N=8/K=4; 01 gives N=16/K=11; 10 gives N=32/K=26; 11 is invalid.
REQ-014 The codeword layout SHALL be extended Hamming (SECDED):
  - bit positions 1..N-1: parity bits at the power-of-two positions; data bits at the remaining positions in ascending order, filled from DATA_IN[0] upward;
  - parity bit at position 2^i = XOR of all positions j with bit i of j set;
  - bit 0 = XOR of bits 1..N-1 (even overall parity).
REQ-015 Decode SHALL compute:
  - syndrome s = XOR of the indices j of all set bits in positions 1..N-1;
  - P = XOR of bits 0..N-1.
REQ-016 Decode classification SHALL be:
  - P=0, s=0: 0 errors;
  - P=1: 1 error, flip bit s before extraction (s=0 means bit 0);
  - P=0, s!=0: 2 errors, extract the data uncorrected.
REQ-017 Input bits SHALL be ignored above K (encode DATA_IN), above N (decode DATA_IN) and above N (NOISE); data_out bits above N (encode) or above K (decode/full) SHALL be 0.
REQ-018 The FSM SHALL have states IDLE, ENC, NOISE, DEC and DONE.
REQ-019 In IDLE with start=1, the block SHALL capture all four inputs into internal registers on that edge and go to:
  - ENC for encode or full mode;
  - DEC for decode mode;
  - DONE directly for an invalid mode or width.
REQ-020 The FSM SHALL have the following transitions:
  - ENC goes to DONE (encode) or NOISE (full);
  - NOISE goes to DEC;
  - DEC goes to DONE;
  - DONE goes to IDLE.
  Each state SHALL last exactly one cycle.
REQ-021 Latency, counted from the start cycle to the operation_done cycle, SHALL be 2 cycles for encode/decode, 4 cycles for full, and 1 cycle for invalid.
REQ-022 data_out and num_of_errors SHALL update on the edge entering DONE and hold until the next entry into DONE; operation_done SHALL be 1 exactly while in DONE.
REQ-023 In encode mode num_of_errors SHALL be 0; an invalid mode or width SHALL give data_out=0 and num_of_errors=0.
REQ-024 start SHALL be ignored outside IDLE; no queuing; captured operands SHALL be unaffected by later input changes.
REQ-025 All outputs SHALL be registered; the block SHALL have no combinational input-to-output path.

Reset
REQ-026 On rst=0 the block SHALL asynchronously force: state=IDLE, data_out=0, num_of_errors=0, operation_done=0, and all internal registers to 0.
REQ-027 Reset during any non-IDLE state SHALL abort the operation; no operation_done SHALL be produced for the aborted request.

Structure
REQ-028 Package ecc_pkg SHALL hold:
  - the state enum;
  - mode constants (ENCODE, DECODE, FULL);
  - width codes;
  - N/K lookup constants.
REQ-029 One combinational sub-module, ecc_hamming_calc, SHALL compute the parity bits, syndrome and overall parity for a 32-bit vector masked to N; it SHALL be used in both ENC and DEC.

Verification
REQ-030 Encode test: CTRL=0, width=0, DATA_IN=0xB, start -> operation_done 2 cycles later, data_out=0xAA, num_of_errors=0.
REQ-031 Full-mode single-error test: CTRL=2, width=0, DATA_IN=0xB, NOISE=0x8 -> done after 4 cycles, data_out=0xB, num_of_errors=1.
REQ-032 Full-mode double-error test: CTRL=2, width=0, DATA_IN=0xB, NOISE=0x30 -> data_out=0x9, num_of_errors=2.
REQ-033 Decode test: CTRL=1, width=0, DATA_IN=0xAB (bit-0 error) -> data_out=0xB, num_of_errors=1; DATA_IN=0xAA -> 0xB, 0.
REQ-034 Busy/invalid test: a second start pulse in ENC is ignored (a single done pulse only); CTRL=3 -> done after 1 cycle with data_out=0.
REQ-035 Reset test: rst low in NOISE state -> outputs 0 immediately; no done pulse; the next start completes normally.
